// File: rtl/ins_decode_queue_pkg.sv
// MIPS ISA constants shared by the decode queue and the controller.
// Provides opcode/funct encodings, the instruction-memory base address,
// the bit positions inside the one-hot class vector, and the class vector type.
`timescale 1ns/1ps
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [31:0] IM_BASE = 32'h0000_3000;

  // Bit positions in the class vector {illegal, j, beq, sw, lw, lui, ori, rtype}
  localparam int unsigned CLS_RTYPE   = 0;
  localparam int unsigned CLS_ORI     = 1;
  localparam int unsigned CLS_LUI     = 2;
  localparam int unsigned CLS_LW      = 3;
  localparam int unsigned CLS_SW      = 4;
  localparam int unsigned CLS_BEQ     = 5;
  localparam int unsigned CLS_J       = 6;
  localparam int unsigned CLS_ILLEGAL = 7;
  localparam int unsigned CLS_W       = 8;

  typedef logic [CLS_W-1:0] ins_cls_t;

endpackage

// File: rtl/ins_decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and the controller.
//   fetch side  : in_valid, in_ins, in_pc -> queue ; in_ready <- queue
//   control     : flush -> queue
//   consumer    : out_ready -> queue ; out_valid, head fields, out_cls,
//                 occupancy <- queue
// Modports: slave = the queue, master = the fetch/controller environment.
`timescale 1ns/1ps
interface ins_decode_queue_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned DEPTH = 2
);
  import mips_isa_pkg::*;

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [31:0]      in_ins;
  logic [PC_W-1:0]  in_pc;
  logic             in_ready;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_ins;
  logic [31:0]      out_pc_byte;
  logic [5:0]       out_op;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [5:0]       out_funct;
  logic [15:0]      out_imm16;
  logic [25:0]      out_imm26;
  ins_cls_t         out_cls;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  in_valid, in_ins, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ins, out_pc_byte, out_op, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_imm26, out_cls, occupancy
  );

  modport master (
    output in_valid, in_ins, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ins, out_pc_byte, out_op, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_imm26, out_cls, occupancy
  );

endinterface

// File: rtl/ins_decode_queue_ins_field_decoder.sv
// Combinational MIPS field splitter and one-hot class decoder.
//   valid in  : instruction word is meaningful; when low every output is 0
//   ins   in  : 32-bit instruction word
//   op/rs/rt/rd/shamt/funct/imm16/imm26 out : raw instruction fields
//   cls   out : one-hot {illegal, j, beq, sw, lw, lui, ori, rtype}
`timescale 1ns/1ps
module ins_field_decoder
  import mips_isa_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] ins,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output ins_cls_t    cls
);

  always_comb begin
    op    = '0;
    rs    = '0;
    rt    = '0;
    rd    = '0;
    shamt = '0;
    funct = '0;
    imm16 = '0;
    imm26 = '0;
    cls   = '0;
    if (valid) begin
      op    = ins[31:26];
      rs    = ins[25:21];
      rt    = ins[20:16];
      rd    = ins[15:11];
      shamt = ins[10:6];
      funct = ins[5:0];
      imm16 = ins[15:0];
      imm26 = ins[25:0];
      unique case (ins[31:26])
        OP_RTYPE: begin
          // Only addu/subu are implemented; every other funct is illegal
          if (ins[5:0] == FN_ADDU || ins[5:0] == FN_SUBU) cls[CLS_RTYPE] = 1'b1;
          else                                            cls[CLS_ILLEGAL] = 1'b1;
        end
        OP_ORI:  cls[CLS_ORI] = 1'b1;
        OP_LUI:  cls[CLS_LUI] = 1'b1;
        OP_LW:   cls[CLS_LW]  = 1'b1;
        OP_SW:   cls[CLS_SW]  = 1'b1;
        OP_BEQ:  cls[CLS_BEQ] = 1'b1;
        OP_J:    cls[CLS_J]   = 1'b1;
        default: cls[CLS_ILLEGAL] = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ins_decode_queue.sv
// Pre-decode FIFO between instruction fetch and the controller.
//   clk  in : rising-edge clock
//   rst  in : asynchronous active-low reset; clears pointers, count and storage
//   bus     : ins_decode_queue_if.slave
//             in_valid/in_ins/in_pc/in_ready : fetch push handshake
//             flush                          : drop every buffered entry
//             out_ready/out_valid            : controller pop handshake
//             out_* fields, out_cls          : decoded head entry (0 when empty)
//             occupancy                      : number of valid entries
// Head outputs are combinational from storage, so an entry pushed on edge N
// is visible right after edge N with no bubble.
`timescale 1ns/1ps
module ins_decode_queue
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned PC_W          = 10,
  parameter logic [31:0] IM_BASE_PARAM = IM_BASE
) (
  input  logic                clk,
  input  logic                rst,
  ins_decode_queue_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]     ins_mem [DEPTH];
  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic            head_valid;
  logic [31:0]     head_ins;
  logic [PC_W-1:0] head_pc;

  always_comb begin
    head_valid = (count != '0);
    // in_ready looks only at registered count so it never depends on out_ready
    bus.in_ready  = (count < CW'(DEPTH));
    bus.out_valid = head_valid;
    push = bus.in_valid & bus.in_ready & ~bus.flush;
    pop  = head_valid & bus.out_ready & ~bus.flush;
    head_ins = ins_mem[rd_ptr];
    head_pc  = pc_mem[rd_ptr];
    bus.out_ins     = head_valid ? head_ins : '0;
    bus.out_pc_byte = head_valid ? (IM_BASE_PARAM + 32'({head_pc, 2'b00})) : '0;
    bus.occupancy   = count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ins_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ins_mem[wr_ptr] <= bus.in_ins;
        pc_mem[wr_ptr]  <= bus.in_pc;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ins_field_decoder u_dec (
    .valid (head_valid),
    .ins   (head_ins),
    .op    (bus.out_op),
    .rs    (bus.out_rs),
    .rt    (bus.out_rt),
    .rd    (bus.out_rd),
    .shamt (bus.out_shamt),
    .funct (bus.out_funct),
    .imm16 (bus.out_imm16),
    .imm26 (bus.out_imm26),
    .cls   (bus.out_cls)
  );

endmodule

// File: tb/tb_ins_decode_queue.sv
// Self-checking bench for ins_decode_queue: scoreboard of pushed entries,
// compared against the head whenever the queue reports a valid entry.
`timescale 1ns/1ps
module tb_ins_decode_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PC_W  = 10;

  typedef struct {
    logic [31:0]     ins;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  entry_t sb[$];

  ins_decode_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  ins_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference class decode written directly from the opcode table
  function automatic logic [7:0] ref_cls(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00:   ref_cls = (fn == 6'h21 || fn == 6'h23) ? 8'h01 : 8'h80;
      6'h0D:   ref_cls = 8'h02;
      6'h0F:   ref_cls = 8'h04;
      6'h23:   ref_cls = 8'h08;
      6'h2B:   ref_cls = 8'h10;
      6'h04:   ref_cls = 8'h20;
      6'h02:   ref_cls = 8'h40;
      default: ref_cls = 8'h80;
    endcase
  endfunction

  // One clock: check head/status against the scoreboard at the negedge,
  // update the scoreboard with what the handshakes imply, then cross the edge.
  task automatic step();
    entry_t e;
    bit do_pop, do_push;
    @(negedge clk);
    chk("occupancy", 64'(bus.occupancy), 64'(sb.size()));
    chk("in_ready",  64'(bus.in_ready),  64'(sb.size() < DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      chk("ins",   64'(bus.out_ins),     64'(e.ins));
      chk("pcb",   64'(bus.out_pc_byte), 64'(32'h3000 + 32'(e.pc) * 4));
      chk("op",    64'(bus.out_op),      64'(e.ins >> 26));
      chk("rs",    64'(bus.out_rs),      64'((e.ins >> 21) & 32'h1F));
      chk("rt",    64'(bus.out_rt),      64'((e.ins >> 16) & 32'h1F));
      chk("rd",    64'(bus.out_rd),      64'((e.ins >> 11) & 32'h1F));
      chk("shamt", 64'(bus.out_shamt),   64'((e.ins >> 6) & 32'h1F));
      chk("funct", 64'(bus.out_funct),   64'(e.ins & 32'h3F));
      chk("imm16", 64'(bus.out_imm16),   64'(e.ins & 32'hFFFF));
      chk("imm26", 64'(bus.out_imm26),   64'(e.ins & 32'h03FF_FFFF));
      chk("cls",   64'(bus.out_cls),     64'(ref_cls(e.ins)));
    end else begin
      chk("ins_empty", 64'(bus.out_ins), 64'h0);
      chk("cls_empty", 64'(bus.out_cls), 64'h0);
      chk("op_empty",  64'(bus.out_op),  64'h0);
    end
    if (bus.flush) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (sb.size() < DEPTH);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.ins = bus.in_ins;
        e.pc  = bus.in_pc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    bus.in_valid = 1'b1;
    bus.in_ins   = ins;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("drain_done", 64'(sb.size()), 64'h0);
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_ins    = 32'h3C01_1234;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held with in_valid high: nothing may enter
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
      chk("rst_occ",       64'(bus.occupancy), 64'h0);
      chk("rst_cls",       64'(bus.out_cls),   64'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;

    // First push after release appears with no bubble
    push_one(32'h3C01_1234, 10'd0);
    chk("lui_op",    64'(bus.out_op),      64'h0F);
    chk("lui_rt",    64'(bus.out_rt),      64'h1);
    chk("lui_imm16", 64'(bus.out_imm16),   64'h1234);
    chk("lui_cls",   64'(bus.out_cls),     64'h04);
    chk("lui_pcb",   64'(bus.out_pc_byte), 64'h3000);
    drain();

    // Backpressure: two fill the queue, the third waits
    push_one(32'h3422_0005, 10'd1);
    push_one(32'h0022_1821, 10'd2);
    chk("bp_full_ready", 64'(bus.in_ready), 64'h0);
    bus.in_valid = 1'b1;
    bus.in_ins   = 32'h8C22_0004;
    bus.in_pc    = 10'd3;
    step();
    chk("bp_held_occ", 64'(bus.occupancy), 64'h2);
    chk("bp_head_ori", 64'(bus.out_cls),   64'h02);
    bus.out_ready = 1'b1;
    step();
    chk("bp_addu_rd",    64'(bus.out_rd),    64'h3);
    chk("bp_addu_funct", 64'(bus.out_funct), 64'h21);
    chk("bp_addu_cls",   64'(bus.out_cls),   64'h01);
    for (int i = 0; i < 10 && sb.size() < 2 && sb[sb.size()-1].pc != 10'd3; i++) step();
    bus.in_valid = 1'b0;
    chk("bp_third_accepted", 64'(sb[sb.size()-1].pc), 64'd3);
    drain();

    // Streaming: one in, one out every cycle
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_ins = 32'h3400_0000 | 32'(i);
      bus.in_pc  = PC_W'(i);
      step();
      chk("stream_pcb", 64'(bus.out_pc_byte), 64'(32'h3000 + 32'(i) * 4));
      chk("stream_occ", 64'(bus.occupancy),   64'h1);
    end
    drain();

    // Flush collides with push and pop
    push_one(32'h1022_0003, 10'd20);
    push_one(32'hAC22_0008, 10'd21);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ins    = 32'h3C05_00FF;
    bus.in_pc     = 10'd22;
    bus.out_ready = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'h0);
    chk("flush_occ",   64'(bus.occupancy), 64'h0);
    step();
    bus.out_ready = 1'b0;

    // Illegal and jump decode
    push_one(32'hFC00_0000, 10'd30);
    chk("ill_op_cls", 64'(bus.out_cls), 64'h80);
    drain();
    push_one(32'h0000_0008, 10'd31);
    chk("ill_jr_cls", 64'(bus.out_cls), 64'h80);
    drain();
    push_one(32'h0800_0C03, 10'd32);
    chk("j_cls",   64'(bus.out_cls),   64'h40);
    chk("j_imm26", 64'(bus.out_imm26), 64'h0C03);
    drain();

    // Asynchronous reset between edges with two entries buffered
    push_one(32'h3C01_0001, 10'd40);
    push_one(32'h3C01_0002, 10'd41);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_occ",   64'(bus.occupancy), 64'h0);
    chk("arst_ready", 64'(bus.in_ready),  64'h1);
    chk("arst_ins",   64'(bus.out_ins),   64'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_one(32'h8C22_0010, 10'd50);
    chk("arst_push_cls", 64'(bus.out_cls),   64'h08);
    chk("arst_push_occ", 64'(bus.occupancy), 64'h1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
